// File: rtl/otf_sd_to_bin_if.sv
// Digit-stream / result bundle for the on-the-fly SD-to-binary converter.
// The slave side is the converter; the master side is whoever feeds digits
// and collects the finished two's-complement result.
interface otf_sd_to_bin_if #(
   parameter int N = 3,   // signed digit width
   parameter int W = 17   // signed result width
) ();

   logic                d_valid;
   logic                d_first;
   logic signed [N-1:0] d_in;
   logic                busy;
   logic                q_valid;
   logic signed [W-1:0] q_out;
   logic                q_err;

   modport slave (
      input  d_valid,
      input  d_first,
      input  d_in,
      output busy,
      output q_valid,
      output q_out,
      output q_err
   );

   modport master (
      output d_valid,
      output d_first,
      output d_in,
      input  busy,
      input  q_valid,
      input  q_out,
      input  q_err
   );

endinterface

// File: rtl/otf_sd_to_bin.sv
// On-the-fly converter: radix-RADIX signed-digit stream (MSD first) to a
// W-bit two's-complement integer. Keeps the Q / QM = Q-1 register pair so
// every digit is absorbed by a shift-and-fill, never a carry chain.
module otf_sd_to_bin #(
   parameter int RADIX  = 4,
   parameter int DIGITS = 8
) (
   input  logic            clk,
   input  logic            reset,
   otf_sd_to_bin_if.slave  bus
);

   localparam int K  = $clog2(RADIX);
   localparam int N  = K + 1;
   localparam int W  = DIGITS * K + 1;
   localparam int CW = $clog2(DIGITS + 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_CONV = 1'b1
   } state_t;

   // Magnitude of a signed digit as an N-bit unsigned value; -RADIX maps to RADIX.
   function automatic logic [N-1:0] digit_mag(input logic signed [N-1:0] d);
      logic [N-1:0] m;
      m = d[N-1] ? (~d + N'(1)) : d;
      return m;
   endfunction

   // Low K bits appended to Q: d itself for d>=0, RADIX-|d| when borrowing from QM.
   function automatic logic [K-1:0] fill_q(input logic signed [N-1:0] d);
      logic [N-1:0] t;
      t = d[N-1] ? (N'(RADIX) - digit_mag(d)) : d;
      return K'(t);
   endfunction

   // Low K bits appended to QM: d-1 for d>0, RADIX-1-|d| when taken from QM.
   function automatic logic [K-1:0] fill_qm(input logic signed [N-1:0] d);
      logic [N-1:0] t;
      t = (!d[N-1] && (d != N'(0))) ? (d - N'(1)) : (N'(RADIX - 1) - digit_mag(d));
      return K'(t);
   endfunction

   // The only out-of-range encoding of an N-bit digit is -RADIX (1 followed by zeros).
   function automatic logic digit_illegal(input logic signed [N-1:0] d);
      return (d == {1'b1, {K{1'b0}}});
   endfunction

   // Registered state and outputs
   state_t              state_q;
   logic [CW-1:0]       cnt_q;
   logic [W-1:0]        q_q;
   logic [W-1:0]        qm_q;
   logic                err_q;
   logic                busy_q;
   logic                q_valid_q;
   logic [W-1:0]        q_out_q;
   logic                q_err_q;

   // Next-state values
   logic [W-1:0]        q_d;
   logic [W-1:0]        qm_d;
   logic [CW-1:0]       cnt_d;
   logic                err_d;

   // Decode helpers
   logic                accept_s;
   logic                first_s;
   logic                last_s;
   logic                neg_s;
   logic                pos_s;
   logic                ill_s;
   logic [W-1:0]        q_base_s;
   logic [W-1:0]        qm_base_s;
   logic [W-1:0]        qs_s;
   logic [W-1:0]        qms_s;
   logic [K-1:0]        fq_s;
   logic [K-1:0]        fqm_s;

   // Digit absorption: choose the shifted source register and append the fill bits.
   always_comb begin
      first_s   = bus.d_first;
      accept_s  = bus.d_valid && (bus.d_first || (state_q == S_CONV));
      neg_s     = bus.d_in[N-1];
      pos_s     = !bus.d_in[N-1] && (bus.d_in != N'(0));
      ill_s     = digit_illegal(bus.d_in);
      // A new frame always starts from the 0 / -1 pair, whatever is left in the registers.
      q_base_s  = first_s ? {W{1'b0}} : q_q;
      qm_base_s = first_s ? {W{1'b1}} : qm_q;
      qs_s      = q_base_s << K;
      qms_s     = qm_base_s << K;
      fq_s      = fill_q(bus.d_in);
      fqm_s     = fill_qm(bus.d_in);
      q_d       = (neg_s ? qms_s : qs_s) | {{(W-K){1'b0}}, fq_s};
      qm_d      = (pos_s ? qs_s : qms_s) | {{(W-K){1'b0}}, fqm_s};
      cnt_d     = first_s ? CW'(1) : (cnt_q + CW'(1));
      last_s    = (cnt_d == CW'(DIGITS));
      err_d     = (first_s ? 1'b0 : err_q) | ill_s;
   end

   // Frame FSM: digit counting, Q/QM update, sticky error and result publication.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= {CW{1'b0}};
         q_q       <= {W{1'b0}};
         qm_q      <= {W{1'b1}};
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         q_valid_q <= 1'b0;
         q_out_q   <= {W{1'b0}};
         q_err_q   <= 1'b0;
      end else begin
         q_valid_q <= 1'b0;
         case (state_q)
            S_IDLE, S_CONV: begin
               if (accept_s) begin
                  q_q  <= q_d;
                  qm_q <= qm_d;
                  if (last_s) begin
                     // Frame complete: publish and return to idle; a d_first on the
                     // next cycle is accepted without touching q_out/q_err.
                     state_q   <= S_IDLE;
                     busy_q    <= 1'b0;
                     cnt_q     <= {CW{1'b0}};
                     err_q     <= 1'b0;
                     q_out_q   <= q_d;
                     q_err_q   <= err_d;
                     q_valid_q <= 1'b1;
                  end else begin
                     // First digit (fresh or aborting restart) or a middle digit.
                     state_q <= S_CONV;
                     busy_q  <= 1'b1;
                     cnt_q   <= cnt_d;
                     err_q   <= err_d;
                  end
               end else begin
                  // Stall: no digit this cycle, everything holds.
                  state_q <= state_q;
                  busy_q  <= busy_q;
                  cnt_q   <= cnt_q;
                  err_q   <= err_q;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               cnt_q   <= {CW{1'b0}};
               err_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy    = busy_q;
   assign bus.q_valid = q_valid_q;
   assign bus.q_out   = q_out_q;
   assign bus.q_err   = q_err_q;

endmodule

// File: tb/tb_otf_sd_to_bin.sv
// Directed bench for otf_sd_to_bin (RADIX=4, DIGITS=4, W=9). Stimulus pushes
// expected results into a scoreboard; a negedge monitor pops on every q_valid.
module tb_otf_sd_to_bin;

   localparam int N = 3;
   localparam int W = 9;

   typedef struct {
      logic signed [W-1:0] q;
      logic                e;
      logic                q_dc;   // value unspecified (illegal digit frame)
      int                  cyc;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc;
   int   checks;
   int   errors;
   int   busy_cycles;
   int   pulses;
   int   pushes;
   exp_t sb[$];

   otf_sd_to_bin_if #(.N(N), .W(W)) bus ();

   otf_sd_to_bin #(.RADIX(4), .DIGITS(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) if (bus.busy) busy_cycles <= busy_cycles + 1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (bus.q_valid) begin
         pulses++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_q_valid: got q_out %0d at cycle %0d expected no pulse",
                     bus.q_out, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (!e.q_dc) chk("q_out", int'(bus.q_out), int'(e.q));
            chk("q_err", int'(bus.q_err), int'(e.e));
            chk("q_valid_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic digit(input int d, input bit first);
      bus.d_valid = 1'b1;
      bus.d_first = first;
      bus.d_in    = N'(d);
      @(posedge clk);
      #1;
      bus.d_valid = 1'b0;
      bus.d_first = 1'b0;
   endtask

   // Idle cycles with garbage on d_in/d_first; must have no effect.
   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         bus.d_in    = N'($urandom);
         bus.d_first = 1'($urandom);
         @(posedge clk);
         #1;
      end
      bus.d_first = 1'b0;
   endtask

   task automatic frame(input int d0, input int d1, input int d2, input int d3, input int g,
                        input int exp_q, input bit exp_e, input bit q_dc);
      int   ds[4];
      exp_t e;
      ds = '{d0, d1, d2, d3};
      for (int i = 0; i < 4; i++) begin
         digit(ds[i], (i == 0));
         if (i == 3) begin
            e.q = W'(exp_q); e.e = exp_e; e.q_dc = q_dc; e.cyc = cyc;
            sb.push_back(e);
            pushes++;
         end else begin
            gap(g);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc = 0; checks = 0; errors = 0; busy_cycles = 0; pulses = 0; pushes = 0;
      bus.d_valid = 1'b0; bus.d_first = 1'b0; bus.d_in = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_q_valid", int'(bus.q_valid), 0);
      chk("rst_q_out", int'(bus.q_out), 0);
      chk("rst_q_err", int'(bus.q_err), 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Continuous frame, busy for exactly 3 cycles
      busy_cycles = 0;
      frame(3, 3, 3, 3, 0, 255, 1'b0, 1'b0);
      repeat (2) @(posedge clk); #1;
      chk("busy_cycles", busy_cycles, 3);

      frame(-3, -3, -3, -3, 0, -255, 1'b0, 1'b0);
      gap(1);
      frame(1, -2, 0, 3, 0, 35, 1'b0, 1'b0);
      gap(1);
      frame(-1, 3, 3, 3, 0, -1, 1'b0, 1'b0);
      gap(1);
      frame(0, 0, 0, -1, 0, -1, 1'b0, 1'b0);
      gap(2);

      // Stalled frame with toggling inputs in the gaps
      frame(1, -2, 0, 3, 2, 35, 1'b0, 1'b0);
      gap(3);

      // Abort after 2 digits, then back-to-back frames
      digit(2, 1'b1);
      digit(1, 1'b0);
      frame(1, 0, 0, 0, 0, 64, 1'b0, 1'b0);
      frame(0, 0, 0, 1, 0, 1, 1'b0, 1'b0);
      gap(2);

      // Illegal digit, then a clean frame clears q_err
      frame(1, -4, 0, 0, 0, 0, 1'b1, 1'b1);
      gap(1);
      frame(0, 0, 0, 2, 0, 2, 1'b0, 1'b0);
      gap(2);

      // Reset mid-frame
      digit(0, 1'b1);
      digit(0, 1'b0);
      #2 reset = 1'b1;
      #2;
      chk("midrst_busy", int'(bus.busy), 0);
      chk("midrst_q_out", int'(bus.q_out), 0);
      chk("midrst_q_valid", int'(bus.q_valid), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      // Digits without d_first are ignored in idle
      digit(1, 1'b0);
      digit(1, 1'b0);
      digit(1, 1'b0);
      digit(1, 1'b0);
      chk("nofirst_busy", int'(bus.busy), 0);
      frame(0, 0, 1, 1, 0, 5, 1'b0, 1'b0);
      gap(4);

      chk("sb_empty", sb.size(), 0);
      chk("pulse_count", pulses, pushes);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
